call_lifetime_bank: RTL and testbench

Multi-channel hardware model of function-local variable lifetime: each channel stands for one callable function with a local counter initialised to `INIT` and bumped by `STEP` per call. The local is either static (persists across calls) or automatic (re-initialised every call), selectable per channel. Calls from all channels are round-robin arbitrated, one per cycle, into a single registered response port with backpressure. It sits in lifetime-semantics regression benches as the synthesizable counterpart of static/automatic function tests.

---
 rtl/call_lifetime_bank_if.sv | 32 +++
 rtl/call_lifetime_bank.sv | 109 ++++++++++
 tb/tb_call_lifetime_bank.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/call_lifetime_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : call_lifetime_bank_if
// Brief    : Call request / response bundle for call_lifetime_bank.
// Revision : 1.0
// ============================================================================
interface call_lifetime_bank_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]   req_valid;
    logic [CHANNELS-1:0]   req_ready;
    logic [2*CHANNELS-1:0] req_mode;
    logic [CHANNELS-1:0]   clear;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [CW-1:0]         rsp_chan;
    logic [WIDTH-1:0]      rsp_data;

    modport master (
        output req_valid, req_mode, clear, rsp_ready,
        input  req_ready, rsp_valid, rsp_chan, rsp_data
    );

    modport slave (
        input  req_valid, req_mode, clear, rsp_ready,
        output req_ready, rsp_valid, rsp_chan, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/call_lifetime_bank.sv
`default_nettype none
// ============================================================================
// Module   : call_lifetime_bank
// Brief    : Per-channel static/automatic call counters, round-robin arbitrated
//            into one registered response slot with backpressure.
// Revision : 1.0
// ============================================================================
module call_lifetime_bank #(
    parameter int CHANNELS       = 4,
    parameter int WIDTH          = 32,
    parameter int INIT           = 2,
    parameter int STEP           = 1,
    parameter bit DEFAULT_STATIC = 1'b1
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    call_lifetime_bank_if.slave bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [WIDTH-1:0] c_init        = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] c_step        = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] c_auto_result = c_init + c_step;

    logic [WIDTH-1:0]    r_st [CHANNELS];
    logic [CW-1:0]       r_rr;
    logic                r_rsp_valid;
    logic [CW-1:0]       r_rsp_chan;
    logic [WIDTH-1:0]    r_rsp_data;

    logic [CHANNELS-1:0] w_eligible;
    logic [CHANNELS-1:0] w_grant;
    logic                w_slot_free;
    logic                w_found;
    logic                w_accept;
    logic                w_static;
    logic [CW-1:0]       w_gidx;
    logic [1:0]          w_mode;
    logic [WIDTH-1:0]    w_result;
    int                  w_cand;

    assign w_slot_free = !r_rsp_valid || bus.rsp_ready;
    // A channel being cleared this cycle is not eligible for a grant.
    assign w_eligible  = bus.req_valid & ~bus.clear;

    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_cand = int'(r_rr) + k;
            if (w_cand >= CHANNELS) begin
                w_cand = w_cand - CHANNELS;
            end
            if (!w_found && w_eligible[w_cand[CW-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_cand[CW-1:0];
            end
        end
    end

    assign w_accept = w_found && w_slot_free && rst_n;

    always_comb begin
        w_grant = '0;
        if (w_accept) begin
            w_grant[w_gidx] = 1'b1;
        end
    end

    assign w_mode   = bus.req_mode[{w_gidx, 1'b0} +: 2];
    // 2'b11 is reserved and behaves as automatic.
    assign w_static = (w_mode == 2'b01) || ((w_mode == 2'b00) && DEFAULT_STATIC);
    assign w_result = w_static ? (r_st[w_gidx] + c_step) : c_auto_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_chan  <= '0;
            r_rsp_data  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_st[i] <= c_init;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.clear[i]) begin
                    r_st[i] <= c_init;
                end else if (w_accept && w_static && (w_gidx == CW'(i))) begin
                    r_st[i] <= w_result;
                end
            end
            if (w_accept) begin
                r_rsp_valid <= 1'b1;
                r_rsp_chan  <= w_gidx;
                r_rsp_data  <= w_result;
                r_rr        <= (w_gidx == CW'(CHANNELS - 1)) ? '0 : w_gidx + 1'b1;
            end else if (bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_chan  = r_rsp_chan;
    assign bus.rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_call_lifetime_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_call_lifetime_bank
// Brief    : Scoreboard bench; two instances (32-bit static default, 4-bit
//            wrapping automatic default) share one stimulus stream.
// Revision : 1.0
// ============================================================================
module tb_call_lifetime_bank;
    localparam int CH   = 4;
    localparam int WA   = 32;
    localparam int IA   = 2;
    localparam int WB   = 4;
    localparam int IB   = 14;
    localparam int STEP = 1;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b1;
    logic [CH-1:0]     req_valid = '0;
    logic [CH-1:0]     clear     = '0;
    logic [2*CH-1:0]   req_mode  = '0;
    logic              rsp_ready = 1'b0;

    call_lifetime_bank_if #(.CHANNELS(CH), .WIDTH(WA)) bus_a ();
    call_lifetime_bank_if #(.CHANNELS(CH), .WIDTH(WB)) bus_b ();

    assign bus_a.req_valid = req_valid;
    assign bus_a.req_mode  = req_mode;
    assign bus_a.clear     = clear;
    assign bus_a.rsp_ready = rsp_ready;
    assign bus_b.req_valid = req_valid;
    assign bus_b.req_mode  = req_mode;
    assign bus_b.clear     = clear;
    assign bus_b.rsp_ready = rsp_ready;

    call_lifetime_bank #(.CHANNELS(CH), .WIDTH(WA), .INIT(IA), .STEP(STEP), .DEFAULT_STATIC(1'b1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    call_lifetime_bank #(.CHANNELS(CH), .WIDTH(WB), .INIT(IB), .STEP(STEP), .DEFAULT_STATIC(1'b0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          chan;
        logic [31:0] data;
    } ent_t;

    ent_t        qa[$];
    ent_t        qb[$];
    int          n_cmp   = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          started = 1'b0;
    logic [31:0] st_a [CH];
    logic [3:0]  st_b [CH];
    int          rr_m;
    bit          busy_m;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            st_a[i] = 32'(IA);
            st_b[i] = 4'(IB);
        end
        rr_m   = 0;
        busy_m = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    // One clock of stimulus; the reference model predicts the grant and result.
    task automatic step(input logic [CH-1:0] v, input logic [2*CH-1:0] m,
                        input logic [CH-1:0] c, input logic r, output int g);
        logic [CH-1:0] exp_g;
        logic [1:0]    md;
        logic [31:0]   ra;
        logic [3:0]    rb;
        @(negedge clk);
        cyc++;
        req_valid = v;
        req_mode  = m;
        clear     = c;
        rsp_ready = r;
        #1;
        g     = -1;
        exp_g = '0;
        if (!busy_m || r) begin
            for (int k = 0; k < CH; k++) begin
                int ch = (rr_m + k) % CH;
                if (g < 0 && v[ch] && !c[ch]) g = ch;
            end
        end
        if (g >= 0) exp_g[g] = 1'b1;
        check("req_ready_a", 32'(bus_a.req_ready), 32'(exp_g));
        check("req_ready_b", 32'(bus_b.req_ready), 32'(exp_g));
        for (int i = 0; i < CH; i++) begin
            if (c[i]) begin
                st_a[i] = 32'(IA);
                st_b[i] = 4'(IB);
            end
        end
        if (g >= 0) begin
            md = m[2*g +: 2];
            if (md == 2'b01 || md == 2'b00) begin
                st_a[g] = st_a[g] + 32'(STEP);
                ra = st_a[g];
            end else begin
                ra = 32'(IA + STEP);
            end
            if (md == 2'b01) begin
                st_b[g] = st_b[g] + 4'(STEP);
                rb = st_b[g];
            end else begin
                rb = 4'(IB + STEP);
            end
            qa.push_back('{cyc, g, ra});
            qb.push_back('{cyc, g, 32'(rb)});
            rr_m   = (g + 1) % CH;
            busy_m = 1'b1;
        end else if (r) begin
            busy_m = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc++;
        rst_n     = 1'b0;
        req_valid = '1;
        #1;
        check("rst_rsp_valid_a", 32'(bus_a.rsp_valid), 0);
        check("rst_rsp_valid_b", 32'(bus_b.rsp_valid), 0);
        check("rst_rsp_chan_a",  32'(bus_a.rsp_chan), 0);
        check("rst_rsp_data_a",  bus_a.rsp_data, 0);
        check("rst_rsp_data_b",  32'(bus_b.rsp_data), 0);
        check("rst_req_ready_a", 32'(bus_a.req_ready), 0);
        check("rst_req_ready_b", 32'(bus_b.req_ready), 0);
        model_reset();
        @(negedge clk);
        cyc++;
        req_valid = '0;
        clear     = '0;
        rst_n     = 1'b1;
        started   = 1'b1;
    endtask

    task automatic mon_one(input string nm, input bit due, input ent_t e, input logic v,
                           input int ch, input logic [31:0] d, output bit pop);
        pop = 1'b0;
        if (due) begin
            check({nm, "_rsp_valid"}, 32'(v), 1);
            check({nm, "_rsp_chan"}, 32'(ch), 32'(e.chan));
            check({nm, "_rsp_data"}, d, e.data);
            pop = rsp_ready;
        end else begin
            check({nm, "_rsp_valid_idle"}, 32'(v), 0);
        end
    endtask

    // Monitor: an entry pushed in cycle N must be presented from cycle N+1 until consumed.
    bit   m_due;
    bit   m_pop;
    ent_t m_e;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && started) begin
                m_due = (qa.size() > 0) && (qa[0].cyc < cyc);
                m_e   = m_due ? qa[0] : '{0, 0, 32'd0};
                mon_one("a", m_due, m_e, bus_a.rsp_valid, int'(bus_a.rsp_chan), bus_a.rsp_data, m_pop);
                if (m_pop) void'(qa.pop_front());
                m_due = (qb.size() > 0) && (qb[0].cyc < cyc);
                m_e   = m_due ? qb[0] : '{0, 0, 32'd0};
                mon_one("b", m_due, m_e, bus_b.rsp_valid, int'(bus_b.rsp_chan), 32'(bus_b.rsp_data), m_pop);
                if (m_pop) void'(qb.pop_front());
            end
        end
    end

    int              g;
    int              guard;
    logic [CH-1:0]   pend;
    logic [CH-1:0]   cl;
    logic [2*CH-1:0] md;

    initial begin
        model_reset();
        do_reset();
        // static, automatic then back to static, default and reserved modes
        repeat (2) step(4'b0001, 8'h01, 4'h0, 1'b1, g);
        repeat (2) step(4'b0010, 8'h08, 4'h0, 1'b1, g);
        step(4'b0010, 8'h04, 4'h0, 1'b1, g);
        repeat (2) step(4'b0100, 8'h00, 4'h0, 1'b1, g);
        repeat (2) step(4'b0100, 8'h30, 4'h0, 1'b1, g);

        do_reset();
        pend  = 4'hF;
        guard = 0;
        while (pend != 0 && guard < 8) begin
            step(pend, 8'h55, 4'h0, 1'b1, g);
            if (g >= 0) pend[g] = 1'b0;
            guard++;
        end
        check("all_four_granted", 32'(pend), 0);
        step(4'b1001, 8'h55, 4'h0, 1'b1, g);
        step(4'b1000, 8'h55, 4'h0, 1'b1, g);

        // backpressure with ch2 waiting
        step(4'b0100, 8'h55, 4'h0, 1'b1, g);
        repeat (3) step(4'b0100, 8'h55, 4'h0, 1'b0, g);
        step(4'b0100, 8'h55, 4'h0, 1'b1, g);
        step(4'b0000, 8'h55, 4'h0, 1'b1, g);

        // clear collides with a request; narrow instance wraps
        step(4'b0011, 8'h55, 4'b0001, 1'b1, g);
        repeat (3) step(4'b0001, 8'h55, 4'h0, 1'b1, g);
        step(4'b0001, 8'h55, 4'b0001, 1'b1, g);
        step(4'b0001, 8'h55, 4'h0, 1'b1, g);

        // reset while a response is held
        step(4'b0001, 8'h55, 4'h0, 1'b0, g);
        step(4'b0000, 8'h55, 4'h0, 1'b0, g);
        do_reset();
        step(4'b0001, 8'h55, 4'h0, 1'b1, g);

        pend = '0;
        repeat (1500) begin
            for (int i = 0; i < CH; i++) begin
                if (!pend[i] && $urandom_range(0, 9) < 3) pend[i] = 1'b1;
                else if (pend[i] && $urandom_range(0, 49) == 0) pend[i] = 1'b0;
                cl[i] = ($urandom_range(0, 29) == 0);
            end
            md = 8'($urandom);
            step(pend, md, cl, ($urandom_range(0, 3) != 0), g);
            if (g >= 0) pend[g] = 1'b0;
        end

        repeat (4) step(4'b0000, 8'h00, 4'h0, 1'b1, g);
        check("drain_a", 32'(qa.size()), 0);
        check("drain_b", 32'(qb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
